// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants: bubble word, default reset PC,
// fetch hold state and the IF/ID pipeline register layout.
package riscv_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry capture of the memory response during a decode stall, plus the
// RUN/HOLD state that selects between the live memory word and the held copy.
module fetch_hold_buf #(
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   stall,
  input  logic [31:0]            rdata,
  output logic [31:0]            word,
  output riscv_pkg::fetch_state_e state
);
  import riscv_pkg::*;

  fetch_state_e state_q;
  logic [31:0]  hold_q;

  // The memory word is only valid for one cycle, so the first stalled edge
  // grabs it; later stalled edges ignore whatever the memory drives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      hold_q  <= NOP_INST;
    end else if (flush) begin
      state_q <= RUN;
      hold_q  <= NOP_INST;
    end else begin
      case (state_q)
        RUN: begin
          if (stall) begin
            hold_q  <= rdata;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign word  = (state_q == HOLD) ? hold_q : rdata;
  assign state = state_q;

endmodule

// File: rtl/if_id_fetch.sv
// Instruction fetch stage with IF/ID register: owns the fetch PC, tracks the
// word in flight from the synchronous instruction memory, stalls and redirects.
module if_id_fetch #(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        misalign_fault,
  output logic [31:0] fetch_count
);
  import riscv_pkg::*;

  logic [31:0]  pc_f_q;
  logic [31:0]  resp_pc_q;
  logic         resp_valid_q;
  ifid_t        ifid_q;
  logic         misalign_q;
  logic [31:0]  count_q;
  logic [31:0]  resp_word;
  fetch_state_e fetch_state;
  logic         fetch_held;

  fetch_hold_buf #(
    .NOP_INST (NOP_INST)
  ) u_hold (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .stall (stall_d),
    .rdata (imem_rdata),
    .word  (resp_word),
    .state (fetch_state)
  );

  assign fetch_held = (fetch_state == HOLD);

  // During HOLD the fetch PC is frozen, so the memory keeps returning the word
  // for pc_f_q and the release edge can treat it as the next response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q       <= RESET_PC;
      resp_pc_q    <= 32'h0;
      resp_valid_q <= 1'b0;
      ifid_q       <= '{inst: NOP_INST, pc: 32'h0, valid: 1'b0};
      misalign_q   <= 1'b0;
      count_q      <= 32'h0;
    end else begin
      misalign_q <= 1'b0;
      if (redirect_valid) begin
        pc_f_q       <= {redirect_pc[31:2], 2'b00};
        resp_valid_q <= 1'b0;
        ifid_q.inst  <= NOP_INST;
        ifid_q.valid <= 1'b0;
        misalign_q   <= (redirect_pc[1:0] != 2'b00);
      end else if (!stall_d) begin
        ifid_q.inst  <= resp_valid_q ? resp_word : NOP_INST;
        ifid_q.pc    <= resp_pc_q;
        ifid_q.valid <= resp_valid_q;
        resp_pc_q    <= pc_f_q;
        resp_valid_q <= 1'b1;
        pc_f_q       <= pc_f_q + 32'd4;
        if (resp_valid_q) count_q <= count_q + 32'd1;
      end
    end
  end

  assign imem_addr      = pc_f_q;
  assign inst_d         = ifid_q.inst;
  assign pc_d           = ifid_q.pc;
  assign pc_plus4_d     = ifid_q.pc + 32'd4;
  assign valid_d        = ifid_q.valid;
  assign misalign_fault = misalign_q;
  assign fetch_count    = count_q;

  // Hold state is visible for debug probing; it does not alter top-level datapath.
  logic unused_held;
  assign unused_held = fetch_held;

endmodule

// File: tb/tb_if_id_fetch.sv
// Bench for if_id_fetch: synchronous memory model returning NOP+addr, a
// stream-level reference model of delivered PCs, and per-scenario tasks.
module tb_if_id_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = NOP;
  logic        stall_d = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] inst_d, pc_d, pc_plus4_d, fetch_count;
  logic        valid_d, misalign_fault;

  logic        reset2 = 1'b1;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2 = NOP;
  logic [31:0] inst_d2, pc_d2, pc_plus4_d2, fetch_count2;
  logic        valid_d2, misalign_fault2;

  if_id_fetch u_dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall_d        (stall_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_d         (inst_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d),
    .misalign_fault (misalign_fault),
    .fetch_count    (fetch_count)
  );

  if_id_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk            (clk),
    .reset          (reset2),
    .imem_addr      (imem_addr2),
    .imem_rdata     (imem_rdata2),
    .stall_d        (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .inst_d         (inst_d2),
    .pc_d           (pc_d2),
    .pc_plus4_d     (pc_plus4_d2),
    .valid_d        (valid_d2),
    .misalign_fault (misalign_fault2),
    .fetch_count    (fetch_count2)
  );

  // Memory: word = NOP + address, one cycle latency. While decode is stalled
  // the memory output is scrambled so only a properly captured word survives.
  always @(posedge clk) begin
    if (stall_d && !redirect_valid) imem_rdata <= $urandom;
    else                            imem_rdata <= NOP + imem_addr;
    imem_rdata2 <= NOP + imem_addr2;
  end

  // reference model: what decode should see, in terms of the delivered stream
  logic        m_valid, m_mis, m_fill;
  logic [31:0] m_inst, m_pc, m_count, m_next;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic assert_reset();
    reset = 1'b1; stall_d = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    m_valid = 1'b0; m_inst = NOP; m_pc = 32'h0; m_count = 32'h0;
    m_mis = 1'b0; m_next = 32'h0; m_fill = 1'b1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // driver: apply one cycle of inputs and advance the model over that edge
  task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
    stall_d = st; redirect_valid = rd; redirect_pc = rpc;
    @(posedge clk);
    m_mis = 1'b0;
    if (rd) begin
      m_valid = 1'b0; m_inst = NOP; m_mis = (rpc[1:0] != 2'b00);
      m_next = {rpc[31:2], 2'b00}; m_fill = 1'b1;
    end else if (!st) begin
      if (m_fill) begin
        m_fill = 1'b0; m_valid = 1'b0; m_inst = NOP;
      end else begin
        m_valid = 1'b1; m_pc = m_next; m_inst = NOP + m_next;
        m_next = m_next + 32'd4; m_count = m_count + 32'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    assert_reset();
    #1;
    n_checks++; if (inst_d !== NOP) begin n_fail++; $display("FAIL reset_inst got=%h exp=%h", inst_d, NOP); end
    n_checks++; if (pc_d !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", pc_d); end
    n_checks++; if (pc_plus4_d !== 32'h4) begin n_fail++; $display("FAIL reset_pc4 got=%h exp=4", pc_plus4_d); end
    n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
    n_checks++; if (misalign_fault !== 1'b0) begin n_fail++; $display("FAIL reset_mis got=%b exp=0", misalign_fault); end
    n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got=%h exp=0", fetch_count); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    release_reset();
  endtask

  task automatic test_sequential();
    tick(1'b0, 1'b0, 32'h0);
    n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL seq_first_bubble got=%b exp=0", valid_d); end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      n_checks++; if (valid_d !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, valid_d); end
      n_checks++; if (pc_d !== m_pc) begin n_fail++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc_d, m_pc); end
      n_checks++; if (inst_d !== m_inst) begin n_fail++; $display("FAIL seq_inst[%0d] got=%h exp=%h", i, inst_d, m_inst); end
      n_checks++; if (pc_plus4_d !== m_pc + 32'd4) begin n_fail++; $display("FAIL seq_pc4[%0d] got=%h exp=%h", i, pc_plus4_d, m_pc + 32'd4); end
      n_checks++; if (fetch_count !== m_count) begin n_fail++; $display("FAIL seq_count[%0d] got=%0d exp=%0d", i, fetch_count, m_count); end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    assert_reset();
    release_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      n_checks++; if (pc_d !== 32'h4 || valid_d !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d] got pc=%h v=%b exp pc=4 v=1", i, pc_d, valid_d); end
      n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL stall_count[%0d] got=%0d exp=2", i, fetch_count); end
    end
    tick(1'b0, 1'b0, 32'h0);
    n_checks++; if (pc_d !== 32'h8 || inst_d !== NOP + 32'h8) begin n_fail++; $display("FAIL stall_release got pc=%h inst=%h exp pc=8 inst=%h", pc_d, inst_d, NOP + 32'h8); end
    tick(1'b0, 1'b0, 32'h0);
    n_checks++; if (pc_d !== 32'hC || inst_d !== NOP + 32'hC) begin n_fail++; $display("FAIL stall_next got pc=%h inst=%h exp pc=c inst=%h", pc_d, inst_d, NOP + 32'hC); end
    n_checks++; if (fetch_count !== 32'd4) begin n_fail++; $display("FAIL stall_final_count got=%0d exp=4", fetch_count); end
  endtask

  task automatic test_redirect();
    logic [31:0] cnt_before;
    cnt_before = m_count;
    tick(1'b1, 1'b1, 32'h100);
    n_checks++; if (valid_d !== 1'b0 || inst_d !== NOP) begin n_fail++; $display("FAIL redir_squash got v=%b inst=%h exp v=0 inst=%h", valid_d, inst_d, NOP); end
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
    tick(1'b0, 1'b0, 32'h0);
    n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL redir_bubble got=%b exp=0", valid_d); end
    n_checks++; if (fetch_count !== cnt_before) begin n_fail++; $display("FAIL redir_count got=%0d exp=%0d", fetch_count, cnt_before); end
    tick(1'b0, 1'b0, 32'h0);
    n_checks++; if (valid_d !== 1'b1 || pc_d !== 32'h100 || inst_d !== NOP + 32'h100) begin n_fail++; $display("FAIL redir_target got v=%b pc=%h inst=%h exp v=1 pc=100", valid_d, pc_d, inst_d); end
    n_checks++; if (fetch_count !== cnt_before + 32'd1) begin n_fail++; $display("FAIL redir_count2 got=%0d exp=%0d", fetch_count, cnt_before + 32'd1); end
  endtask

  task automatic test_misalign();
    tick(1'b0, 1'b1, 32'h102);
    n_checks++; if (misalign_fault !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got=%b exp=1", misalign_fault); end
    tick(1'b0, 1'b0, 32'h0);
    n_checks++; if (misalign_fault !== 1'b0) begin n_fail++; $display("FAIL mis_clear got=%b exp=0", misalign_fault); end
    tick(1'b0, 1'b0, 32'h0);
    n_checks++; if (pc_d !== 32'h100 || valid_d !== 1'b1) begin n_fail++; $display("FAIL mis_resume got pc=%h v=%b exp pc=100 v=1", pc_d, valid_d); end
  endtask

  task automatic test_random();
    logic st, rd;
    logic [31:0] rpc;
    for (int i = 0; i < 300; i++) begin
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      tick(st, rd, rpc);
      n_checks++; if (valid_d !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, valid_d, m_valid); end
      n_checks++; if (inst_d !== m_inst) begin n_fail++; $display("FAIL rnd_inst[%0d] got=%h exp=%h", i, inst_d, m_inst); end
      if (m_valid) begin
        n_checks++; if (pc_d !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, pc_d, m_pc); end
        n_checks++; if (pc_plus4_d !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_pc4[%0d] got=%h exp=%h", i, pc_plus4_d, m_pc + 32'd4); end
      end
      n_checks++; if (misalign_fault !== m_mis) begin n_fail++; $display("FAIL rnd_mis[%0d] got=%b exp=%b", i, misalign_fault, m_mis); end
      n_checks++; if (fetch_count !== m_count) begin n_fail++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, fetch_count, m_count); end
    end
  endtask

  task automatic test_reset_mid_hold();
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    #2;
    assert_reset();
    #1;
    n_checks++; if (inst_d !== NOP || valid_d !== 1'b0) begin n_fail++; $display("FAIL rst_hold_if got inst=%h v=%b exp inst=%h v=0", inst_d, valid_d, NOP); end
    n_checks++; if (pc_d !== 32'h0 || pc_plus4_d !== 32'h4) begin n_fail++; $display("FAIL rst_hold_pc got pc=%h pc4=%h exp 0/4", pc_d, pc_plus4_d); end
    n_checks++; if (fetch_count !== 32'h0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_hold_cnt got cnt=%0d addr=%h exp 0/0", fetch_count, imem_addr); end
    @(negedge clk);
    release_reset();
    tick(1'b0, 1'b0, 32'h0);
    n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL rst_hold_bubble got=%b exp=0", valid_d); end
    tick(1'b0, 1'b0, 32'h0);
    n_checks++; if (valid_d !== 1'b1 || pc_d !== 32'h0 || inst_d !== NOP) begin n_fail++; $display("FAIL rst_hold_restart got v=%b pc=%h inst=%h exp v=1 pc=0 inst=%h", valid_d, pc_d, inst_d, NOP); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc[4];
    logic [31:0] exp_cnt[4];
    logic        exp_v[4];
    exp_v   = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_pc  = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_cnt = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    @(negedge clk);
    n_checks++; if (imem_addr2 !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_reset_addr got=%h exp=fffffff8", imem_addr2); end
    reset2 = 1'b0;
    force u_wrap.count_q = 32'hFFFF_FFFE;
    #1;
    release u_wrap.count_q;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (valid_d2 !== exp_v[i]) begin n_fail++; $display("FAIL wrap_valid[%0d] got=%b exp=%b", i, valid_d2, exp_v[i]); end
      if (exp_v[i]) begin
        n_checks++; if (pc_d2 !== exp_pc[i] || inst_d2 !== NOP + exp_pc[i]) begin n_fail++; $display("FAIL wrap_pc[%0d] got pc=%h inst=%h exp pc=%h", i, pc_d2, inst_d2, exp_pc[i]); end
        n_checks++; if (pc_plus4_d2 !== exp_pc[i] + 32'd4) begin n_fail++; $display("FAIL wrap_pc4[%0d] got=%h exp=%h", i, pc_plus4_d2, exp_pc[i] + 32'd4); end
      end
      n_checks++; if (fetch_count2 !== exp_cnt[i]) begin n_fail++; $display("FAIL wrap_count[%0d] got=%h exp=%h", i, fetch_count2, exp_cnt[i]); end
    end
    n_checks++; if (misalign_fault2 !== 1'b0) begin n_fail++; $display("FAIL wrap_mis got=%b exp=0", misalign_fault2); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misalign();
    test_random();
    test_reset_mid_hold();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_fetch.md
Name: if_id_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode-side immediate generator.
- Owns the fetch PC and drives the synchronous instruction memory (1-cycle read latency).
- Holds a fetched word across decode stalls and squashes wrong-path words on redirect.
- Presents inst_d/pc_d to decode; inst_d feeds the immediate generator's instruction input.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
NOP_INST, 32'h0000_0013, bubble word (addi x0,x0,0) driven on inst_d when invalid

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_addr  out  32  fetch address; combinational from pc_f_q
imem_rdata  in  32  instruction for the address presented in the previous cycle
stall_d  in  1  decode not accepting; hold IF/ID and fetch PC
redirect_valid  in  1  taken branch/jump from EX; flush and refetch
redirect_pc  in  32  redirect target
inst_d  out  32  IF/ID instruction to decode / immediate generator
pc_d  out  32  PC of inst_d
pc_plus4_d  out  32  pc_d + 4, modulo 2^32
valid_d  out  1  inst_d is a real (non-squashed) instruction
misalign_fault  out  1  one-cycle pulse: redirect target had [1:0] != 0
fetch_count  out  32  count of instructions handed to decode

Behaviour:
Reset (asynchronous):
- pc_f_q = RESET_PC; resp_pc_q = 0; resp_valid_q = 0; state = RUN; hold_q = NOP_INST.
- inst_d = NOP_INST; pc_d = 0; pc_plus4_d = 4; valid_d = 0; misalign_fault = 0; fetch_count = 0.
- Reset asserted mid-operation discards all in-flight, held and IF/ID content.

Internal state:
- resp_pc_q / resp_valid_q track the word arriving on imem_rdata this cycle.
- The "response word" is imem_rdata in RUN and hold_q in HOLD.

Edge priority, highest first:
1. redirect_valid = 1 (wins over stall_d):
   - pc_f_q <= {redirect_pc[31:2], 2'b00}; resp_valid_q <= 0.
   - IF/ID <= NOP_INST / valid_d 0; hold_q discarded; state <= RUN.
   - misalign_fault <= (redirect_pc[1:0] != 0).
2. State RUN, stall_d = 1:
   - hold_q <= imem_rdata; state <= HOLD.
   - pc_f_q, resp_*, IF/ID and fetch_count unchanged.
3. State RUN, stall_d = 0:
   - IF/ID <= {imem_rdata, resp_pc_q, resp_valid_q}.
   - resp_pc_q <= pc_f_q; resp_valid_q <= 1; pc_f_q <= pc_f_q + 4.
4. State HOLD, stall_d = 1: everything holds.
5. State HOLD, stall_d = 0:
   - IF/ID <= {hold_q, resp_pc_q, resp_valid_q}.
   - resp_pc_q <= pc_f_q; resp_valid_q <= 1; pc_f_q <= pc_f_q + 4; state <= RUN.
   - Correct because imem_addr stayed at pc_f_q throughout HOLD, so the next imem_rdata is that word.

Outputs and counters:
- If the selected valid bit is 0, IF/ID loads inst_d = NOP_INST.
- misalign_fault is 0 on every edge without a misaligned redirect.
- Latency: reset deasserts in cycle 0; first valid_d=1 (pc_d = RESET_PC) after the 2nd unstalled edge.
- Redirect: first target instruction on inst_d after the 2nd unstalled edge following the redirect edge.
- fetch_count increments on each edge where IF/ID loads with valid = 1; it wraps 32'hFFFF_FFFF -> 0.
- PC arithmetic wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No exception.

Decomposition:
- Package riscv_pkg holds: NOP_INST, RESET_PC default, the fetch state enum {RUN, HOLD}, and the IF/ID struct {inst, pc, valid}.
- One sub-module: fetch_hold_buf, the single-entry capture register plus RUN/HOLD state and response-word mux.
- Parent keeps the PC, redirect, IF/ID register and counter.

Test Plan:
- Reset, no stall, imem returns 32'h0000_0013 + addr -> valid_d rises after the 2nd edge with pc_d=0, then pc_d 4, 8, 12; fetch_count 1, 2, 3.
- stall_d high 3 cycles while word at pc 8 is arriving, imem changes data during stall -> on release inst_d = word captured for pc 8, then pc 12; no skip, no duplicate.
- redirect_valid with redirect_pc=32'h100 while stall_d=1 -> next cycle valid_d=0, inst_d=32'h13; pc_d=32'h100 valid after the 2nd unstalled edge; fetch_count does not count the bubble.
- redirect_pc=32'h102 -> misalign_fault pulses exactly one cycle; fetch resumes at 32'h100.
- Start with RESET_PC=32'hFFFF_FFF8 and preload fetch_count near 32'hFFFF_FFFF via force -> pc_d sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; fetch_count wraps to 0.
- Assert reset mid-HOLD -> all outputs immediately at reset values; after release, fetch restarts at RESET_PC with no stale held word.
